// File: rtl/bbox_draw.sv
// Bounding-box outline renderer: captures a filter box, validates it and
// writes a 1-pixel BOX_COLOR rectangle into the RGB444 frame buffer.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   bbox_valid, x_*, y_*  box from colour filter (stable while valid)
//   bbox_ack              one-cycle capture pulse back to the filter
//   wr_en/wr_addr/wr_data frame-buffer write port, one pixel per cycle
//   busy                  high whenever not idle
//   draw_done/draw_error  completion status, held until draw_ack
//   draw_ack              controller acknowledge of draw_done
module bbox_draw #(
    parameter int             IMG_W     = 320,
    parameter int             IMG_H     = 240,
    parameter int             COORD_W   = 9,
    parameter int             ADDR_W    = 17,
    parameter int             PIX_W     = 12,
    parameter logic [PIX_W-1:0] BOX_COLOR = 12'hF00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bbox_valid,
    input  logic [COORD_W-1:0] x_min,
    input  logic [COORD_W-1:0] x_max,
    input  logic [COORD_W-1:0] y_min,
    input  logic [COORD_W-1:0] y_max,
    output logic               bbox_ack,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [PIX_W-1:0]   wr_data,
    output logic               busy,
    output logic               draw_done,
    output logic               draw_error,
    input  logic               draw_ack
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_TOP    = 3'd2;
    localparam logic [2:0] S_BOTTOM = 3'd3;
    localparam logic [2:0] S_LEFT   = 3'd4;
    localparam logic [2:0] S_RIGHT  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam logic [COORD_W-1:0] W_LIM = COORD_W'(IMG_W);
    localparam logic [COORD_W-1:0] H_LIM = COORD_W'(IMG_H);
    localparam logic [ADDR_W-1:0]  W_MUL = ADDR_W'(IMG_W);

    logic [2:0]         state;
    logic [2:0]         state_n;
    logic [COORD_W-1:0] bx0, bx1, by0, by1;
    logic [COORD_W-1:0] cnt;
    logic [COORD_W-1:0] cnt_n;
    logic [COORD_W-1:0] px, py;
    logic               pix_en;
    logic               box_bad;
    logic [ADDR_W-1:0]  pix_addr;
    logic               in_final;
    logic               capture;

    assign box_bad = (bx0 > bx1) || (by0 > by1) ||
                     (bx1 >= W_LIM) || (by1 >= H_LIM);

    // CHECK guarantees py < IMG_H and px < IMG_W, so this fits ADDR_W.
    assign pix_addr = ADDR_W'(py) * W_MUL + ADDR_W'(px);

    assign in_final = (state == S_DONE) || (state == S_ERR);
    assign capture  = (state == S_IDLE) && bbox_valid;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pix_en  = 1'b0;
        px      = cnt;
        py      = by0;
        case (state)
            S_IDLE: begin
                if (bbox_valid) state_n = S_CHECK;
            end
            S_CHECK: begin
                if (box_bad) begin
                    state_n = S_ERR;
                end else begin
                    state_n = S_TOP;
                    cnt_n   = bx0;
                end
            end
            S_TOP: begin
                pix_en = 1'b1;
                px     = cnt;
                py     = by0;
                if (cnt == bx1) begin
                    state_n = S_BOTTOM;
                    cnt_n   = bx0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_BOTTOM: begin
                pix_en = 1'b1;
                px     = cnt;
                py     = by1;
                if (cnt == bx1) begin
                    state_n = S_LEFT;
                    cnt_n   = by0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_LEFT: begin
                pix_en = 1'b1;
                px     = bx0;
                py     = cnt;
                if (cnt == by1) begin
                    state_n = S_RIGHT;
                    cnt_n   = by0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_RIGHT: begin
                pix_en = 1'b1;
                px     = bx1;
                py     = cnt;
                if (cnt == by1) begin
                    state_n = S_DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DONE, S_ERR: begin
                // Only an ack of a visible draw_done releases the block.
                if (draw_ack && draw_done) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bx0        <= '0;
            bx1        <= '0;
            by0        <= '0;
            by1        <= '0;
            bbox_ack   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            draw_done  <= 1'b0;
            draw_error <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bbox_ack <= capture;
            if (capture) begin
                bx0 <= x_min;
                bx1 <= x_max;
                by0 <= y_min;
                by1 <= y_max;
            end
            wr_en   <= pix_en;
            wr_data <= pix_en ? BOX_COLOR : '0;
            if (pix_en) wr_addr <= pix_addr;
            busy <= (state_n != S_IDLE);
            // Status rises one cycle after entering DONE/ERR, i.e. the
            // cycle after the final write, and drops once acknowledged.
            draw_done  <= in_final && (state_n != S_IDLE);
            draw_error <= (state == S_ERR) && (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_bbox_draw.sv
// Self-checking bench for bbox_draw: directed corner boxes plus randomized
// boxes compared against a list-of-pixels outline model.
module tb_bbox_draw;

    logic        clk = 1'b0;
    logic        reset;
    logic        bbox_valid;
    logic [8:0]  x_min, x_max, y_min, y_max;
    logic        bbox_ack;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        draw_done;
    logic        draw_error;
    logic        draw_ack;

    int errors = 0;
    int checks = 0;

    bbox_draw dut (
        .clk        (clk),
        .reset      (reset),
        .bbox_valid (bbox_valid),
        .x_min      (x_min),
        .x_max      (x_max),
        .y_min      (y_min),
        .y_max      (y_max),
        .bbox_ack   (bbox_ack),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .draw_done  (draw_done),
        .draw_error (draw_error),
        .draw_ack   (draw_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Outline model: every pixel of top row, bottom row, left column,
    // right column in drawing order; empty list for a rejected box.
    task automatic model(input int x0, input int x1, input int y0,
                         input int y1, output bit err, output int q[$]);
        q = {};
        err = (x0 > x1) || (y0 > y1) || (x1 >= 320) || (y1 >= 240);
        if (!err) begin
            for (int x = x0; x <= x1; x++) q.push_back(y0 * 320 + x);
            for (int x = x0; x <= x1; x++) q.push_back(y1 * 320 + x);
            for (int y = y0; y <= y1; y++) q.push_back(y * 320 + x0);
            for (int y = y0; y <= y1; y++) q.push_back(y * 320 + x1);
        end
    endtask

    task automatic drive_box(input int x0, input int x1,
                             input int y0, input int y1);
        x_min = 9'(x0);
        x_max = 9'(x1);
        y_min = 9'(y0);
        y_max = 9'(y1);
        bbox_valid = 1'b1;
    endtask

    // Waits for draw_done and counts writes/ack pulses on the way.
    task automatic collect(input int hold, input int exp_q[$],
                           output int n_wr, output int bad, output int first,
                           output int acks, output int cyc, output bit seen);
        n_wr = 0; bad = 0; first = -1; acks = 0; cyc = 0; seen = 0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc >= hold) bbox_valid = 1'b0;
            if (bbox_ack) acks++;
            if (wr_en) begin
                if (first < 0) first = cyc;
                if (n_wr >= exp_q.size() || int'(wr_addr) != exp_q[n_wr] ||
                    wr_data != 12'hF00) bad++;
                n_wr++;
            end
            if (draw_done) seen = 1;
        end
    endtask

    task automatic run_box(input string nm, input int x0, input int x1,
                           input int y0, input int y1,
                           input int hold, input int ack_dly);
        int  exp_q[$];
        bit  exp_err, seen;
        int  n_wr, bad, first, acks, cyc, held;
        model(x0, x1, y0, y1, exp_err, exp_q);
        @(negedge clk);
        drive_box(x0, x1, y0, y1);
        collect(hold, exp_q, n_wr, bad, first, acks, cyc, seen);
        bbox_valid = 1'b0;
        check({nm, " done_seen"}, int'(seen), 1);
        check({nm, " bbox_ack_pulses"}, acks, 1);
        check({nm, " writes"}, n_wr, exp_q.size());
        check({nm, " addr_data_bad"}, bad, 0);
        if (exp_q.size() > 0) check({nm, " first_wr_cycle"}, first, 3);
        check({nm, " done_cycle"}, cyc, exp_q.size() + 3);
        check({nm, " draw_error"}, int'(draw_error), int'(exp_err));
        held = 0;
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            if (draw_done && busy && !wr_en && draw_error == exp_err) held++;
        end
        if (ack_dly > 0) check({nm, " done_held"}, held, ack_dly);
        draw_ack = 1'b1;
        @(negedge clk);
        draw_ack = 1'b0;
        check({nm, " done_clr"}, int'(draw_done), 0);
        check({nm, " err_clr"}, int'(draw_error), 0);
        check({nm, " busy_clr"}, int'(busy), 0);
    endtask

    initial begin
        int x0, x1, y0, y1, cnt, wait_c;
        reset = 1'b1;
        bbox_valid = 1'b0;
        draw_ack = 1'b0;
        x_min = '0; x_max = '0; y_min = '0; y_max = '0;
        repeat (3) @(negedge clk);
        check("rst wr_en", int'(wr_en), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(draw_done), 0);
        check("rst ack", int'(bbox_ack), 0);
        check("rst addr", int'(wr_addr), 0);
        reset = 1'b0;

        run_box("doc_box", 10, 13, 20, 22, 1, 0);
        run_box("empty", 319, 0, 239, 0, 1, 2);
        run_box("pixel", 319, 319, 239, 239, 1, 0);
        run_box("xmax320", 0, 320, 0, 5, 1, 0);
        run_box("ymax240", 0, 3, 10, 240, 1, 0);
        run_box("row", 5, 40, 7, 7, 1, 1);
        run_box("col", 100, 100, 0, 239, 1, 0);
        run_box("hold10", 10, 13, 20, 22, 10, 5);

        // Reset after two writes of the top edge.
        @(negedge clk);
        drive_box(10, 13, 20, 22);
        cnt = 0;
        wait_c = 0;
        while (cnt < 2 && wait_c < 50) begin
            @(negedge clk);
            wait_c++;
            bbox_valid = 1'b0;
            if (wr_en) cnt++;
        end
        check("rst_mid two_writes", cnt, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid wr_en", int'(wr_en), 0);
        check("rst_mid busy", int'(busy), 0);
        check("rst_mid addr", int'(wr_addr), 0);
        check("rst_mid data", int'(wr_data), 0);
        repeat (3) @(negedge clk);
        check("rst_mid quiet", int'(wr_en | busy | draw_done), 0);
        run_box("after_rst", 0, 2, 0, 1, 1, 0);

        // draw_ack together with a new bbox_valid: accepted one cycle later.
        @(negedge clk);
        drive_box(1, 1, 1, 1);
        wait_c = 0;
        while (!draw_done && wait_c < 100) begin
            @(negedge clk);
            wait_c++;
            bbox_valid = 1'b0;
        end
        check("ovl first_done", int'(draw_done), 1);
        drive_box(2, 3, 4, 5);
        draw_ack = 1'b1;
        @(negedge clk);
        draw_ack = 1'b0;
        check("ovl no_ack_yet", int'(bbox_ack), 0);
        check("ovl busy_low", int'(busy), 0);
        @(negedge clk);
        bbox_valid = 1'b0;
        check("ovl ack", int'(bbox_ack), 1);
        wait_c = 0;
        cnt = 0;
        while (!draw_done && wait_c < 100) begin
            @(negedge clk);
            wait_c++;
            if (wr_en) cnt++;
        end
        check("ovl writes", cnt, 8);
        draw_ack = 1'b1;
        @(negedge clk);
        draw_ack = 1'b0;

        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                x0 = $urandom_range(0, 511);
                x1 = $urandom_range(0, 511);
                y0 = $urandom_range(0, 511);
                y1 = $urandom_range(0, 511);
            end else begin
                x0 = $urandom_range(0, 319);
                x1 = x0 + $urandom_range(0, (319 - x0 < 30) ? 319 - x0 : 30);
                y0 = $urandom_range(0, 239);
                y1 = y0 + $urandom_range(0, (239 - y0 < 30) ? 239 - y0 : 30);
            end
            run_box($sformatf("rnd%0d", it), x0, x1, y0, y1,
                    1, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
